// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronise and debounce both player buttons; emit one-cycle
//            press, tie and false-start pulses for the game core.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic l_raw,
  input  logic r_raw,
  input  logic game_en,
  output logic l_level,
  output logic r_level,
  output logic l_pulse,
  output logic r_pulse,
  output logic tie_pulse,
  output logic false_start
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Channel 0 is the left button, channel 1 the right button.
  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] w_rise;

  assign w_raw = {r_raw, l_raw};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_chan
      logic             r_s1;
      logic             r_s2;
      logic             r_level;
      logic [CNT_W-1:0] r_cnt;
      logic             w_differ;
      logic             w_done;

      assign w_differ = (r_s2 != r_level);
      assign w_done   = w_differ && (r_cnt == c_CNT_LAST);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_level <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_s1 <= w_raw[i];
          r_s2 <= r_s1;
          // Count stays below DEB_CYCLES-1 except on the accepting edge, so it never wraps.
          if (!w_differ) begin
            r_cnt <= '0;
          end else if (w_done) begin
            r_level <= r_s2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_level[i] = r_level;
      assign w_rise[i]  = w_done && r_s2;
    end
  endgenerate

  logic r_l_pulse;
  logic r_r_pulse;
  logic r_tie_pulse;
  logic r_false_start;

  // Pulses register on the same edge the level is accepted, so both appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_l_pulse     <= 1'b0;
      r_r_pulse     <= 1'b0;
      r_tie_pulse   <= 1'b0;
      r_false_start <= 1'b0;
    end else begin
      r_l_pulse     <= game_en  &&  w_rise[0] && !w_rise[1];
      r_r_pulse     <= game_en  &&  w_rise[1] && !w_rise[0];
      r_tie_pulse   <= game_en  &&  w_rise[0] &&  w_rise[1];
      r_false_start <= !game_en && (w_rise[0] ||  w_rise[1]);
    end
  end

  assign l_level     = w_level[0];
  assign r_level     = w_level[1];
  assign l_pulse     = r_l_pulse;
  assign r_pulse     = r_r_pulse;
  assign tie_pulse   = r_tie_pulse;
  assign false_start = r_false_start;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Directed self-checking bench for button_conditioner (DEB_CYCLES=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  logic clk;
  logic rst;
  logic l_raw;
  logic r_raw;
  logic game_en;
  logic l_level;
  logic r_level;
  logic l_pulse;
  logic r_pulse;
  logic tie_pulse;
  logic false_start;

  int tests;
  int fails;

  // Observation order: {l_level, r_level, l_pulse, r_pulse, tie_pulse, false_start}
  logic [5:0] w_obs;
  assign w_obs = {l_level, r_level, l_pulse, r_pulse, tie_pulse, false_start};

  button_conditioner #(
    .DEB_CYCLES(4),
    .CNT_W     (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .l_raw      (l_raw),
    .r_raw      (r_raw),
    .game_en    (game_en),
    .l_level    (l_level),
    .r_level    (r_level),
    .l_pulse    (l_pulse),
    .r_pulse    (r_pulse),
    .tie_pulse  (tie_pulse),
    .false_start(false_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release both buttons and let the levels fall back to 0.
  task automatic release_all(input string name);
    l_raw = 1'b0;
    r_raw = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    tests++;
    if (w_obs !== 6'b000000) begin
      fails++;
      $display("FAIL %s release: got %b expected %b", name, w_obs, 6'b000000);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; l_raw = 1'b0; r_raw = 1'b0; game_en = 1'b0;
    tick();
    tick();
    tests++;
    if (w_obs !== 6'b000000) begin
      fails++;
      $display("FAIL reset_state: got %b expected %b", w_obs, 6'b000000);
    end
  endtask

  task automatic test_single_press();
    logic [5:0] exp;
    rst = 1'b0; game_en = 1'b1; l_raw = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      tick();
      exp = (k >= 6) ? 6'b100000 : 6'b000000;
      if (k == 6) exp = exp | 6'b001000;
      tests++;
      if (w_obs !== exp) begin
        fails++;
        $display("FAIL single_press tick %0d: got %b expected %b", k, w_obs, exp);
      end
    end
    l_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (k >= 6) ? 6'b000000 : 6'b100000;
      tests++;
      if (w_obs !== exp) begin
        fails++;
        $display("FAIL single_release tick %0d: got %b expected %b", k, w_obs, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    logic [5:0] exp;
    pat = 5'b01101; // applied LSB first: 1,0,1,1,0
    game_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      r_raw = pat[k];
      tick();
      tests++;
      if (w_obs !== 6'b000000) begin
        fails++;
        $display("FAIL bounce tick %0d: got %b expected %b", k, w_obs, 6'b000000);
      end
    end
    r_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = (k >= 6) ? 6'b010000 : 6'b000000;
      if (k == 6) exp = exp | 6'b000100;
      tests++;
      if (w_obs !== exp) begin
        fails++;
        $display("FAIL bounce_steady tick %0d: got %b expected %b", k, w_obs, exp);
      end
    end
    release_all("bounce");
  endtask

  task automatic test_tie();
    logic [5:0] exp;
    game_en = 1'b1; l_raw = 1'b1; r_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 6) ? 6'b110000 : 6'b000000;
      if (k == 6) exp = exp | 6'b000010;
      tests++;
      if (w_obs !== exp) begin
        fails++;
        $display("FAIL tie tick %0d: got %b expected %b", k, w_obs, exp);
      end
    end
    release_all("tie");
    // Simultaneous press while idle gives exactly one false_start.
    game_en = 1'b0; l_raw = 1'b1; r_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 6) ? 6'b110000 : 6'b000000;
      if (k == 6) exp = exp | 6'b000001;
      tests++;
      if (w_obs !== exp) begin
        fails++;
        $display("FAIL tie_idle tick %0d: got %b expected %b", k, w_obs, exp);
      end
    end
    release_all("tie_idle");
  endtask

  task automatic test_false_start();
    logic [5:0] exp;
    game_en = 1'b0; l_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 6) ? 6'b100000 : 6'b000000;
      if (k == 6) exp = exp | 6'b000001;
      tests++;
      if (w_obs !== exp) begin
        fails++;
        $display("FAIL false_start tick %0d: got %b expected %b", k, w_obs, exp);
      end
    end
    game_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests++;
      if (w_obs !== 6'b100000) begin
        fails++;
        $display("FAIL held_enable tick %0d: got %b expected %b", k, w_obs, 6'b100000);
      end
    end
    release_all("false_start");
    l_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 6) ? 6'b100000 : 6'b000000;
      if (k == 6) exp = exp | 6'b001000;
      tests++;
      if (w_obs !== exp) begin
        fails++;
        $display("FAIL repress tick %0d: got %b expected %b", k, w_obs, exp);
      end
    end
    release_all("repress");
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    game_en = 1'b1; l_raw = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if (w_obs !== 6'b000000) begin
        fails++;
        $display("FAIL pre_reset tick %0d: got %b expected %b", k, w_obs, 6'b000000);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (w_obs !== 6'b000000) begin
      fails++;
      $display("FAIL mid_reset: got %b expected %b", w_obs, 6'b000000);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 6) ? 6'b100000 : 6'b000000;
      if (k == 6) exp = exp | 6'b001000;
      tests++;
      if (w_obs !== exp) begin
        fails++;
        $display("FAIL post_reset tick %0d: got %b expected %b", k, w_obs, exp);
      end
    end
    release_all("reset_mid");
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    game_en = 1'b1; l_raw = 1'b1;
    tick();
    tests++;
    if (w_obs !== 6'b000000) begin
      fails++;
      $display("FAIL stagger tick 1: got %b expected %b", w_obs, 6'b000000);
    end
    r_raw = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      tick();
      exp = 6'b000000;
      if (k >= 6) exp = exp | 6'b100000;
      if (k >= 7) exp = exp | 6'b010000;
      if (k == 6) exp = exp | 6'b001000;
      if (k == 7) exp = exp | 6'b000100;
      tests++;
      if (w_obs !== exp) begin
        fails++;
        $display("FAIL stagger tick %0d: got %b expected %b", k, w_obs, exp);
      end
    end
    release_all("stagger");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; l_raw = 1'b0; r_raw = 1'b0; game_en = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_tie();
    test_false_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
